// File: rtl/key_pkg.sv
// key_input shared types and constants.
// KEY_LONG_PRESS_EN (see key_debounce_ch) enables the long-press pulse.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } key_st_t;

  localparam int KEY_DEB_CYC_50M  = 1_000_000;
  localparam int KEY_LONG_CYC_50M = 50_000_000;

  localparam int KEY_DEB_CYC_SIM  = 8;
  localparam int KEY_LONG_CYC_SIM = 32;

  function automatic logic key_held(input key_st_t s);
    return (s == PRESSED) || (s == RELEASE_CHK);
  endfunction

endpackage

// File: rtl/key_if.sv
// Key pins in, debounced level and event pulses out.
// slave = key_input block, master = board/pattern-logic side.
interface key_if #(
  parameter int KEY_NUM = 4
);

  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] key_state;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;

  modport slave (
    input  key_in,
    output key_state,
    output key_press,
    output key_release,
    output key_long
  );

  modport master (
    output key_in,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long
  );

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop sync, debounce FSM, optional hold counter.
// Hold counter / key_long built only with KEY_LONG_PRESS_EN defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = KEY_DEB_CYC_50M,
  parameter int LONG_CYC     = KEY_LONG_CYC_50M
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    sync_q;
  logic          sync;
  key_st_t       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  assign sync = sync_q[1];

  // Sync flops idle at 1 so reset looks like a released key.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (!sync) begin
          st_d  = PRESS_CHK;
          cnt_d = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_CHK: begin
        if (sync) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          st_d    = PRESSED;
          state_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (sync) begin
          st_d  = RELEASE_CHK;
          cnt_d = CNT_ONE;
        end
      end
      RELEASE_CHK: begin
        if (!sync) begin
          st_d  = PRESSED;
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          st_d    = IDLE;
          state_d = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_TRIG = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Counts cycles since the press pulse; saturates so it fires once.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!key_held(st_d)) begin
      hold_d = '0;
    end else if (key_held(st_q) && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
      long_d = (hold_q == HOLD_TRIG);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_input.sv
// Debounced multi-key input: KEY_NUM independent key_debounce_ch lanes.
// Optional long-press pulse via KEY_LONG_PRESS_EN.
module key_input
  import key_pkg::*;
#(
  parameter int KEY_NUM      = 4,
  parameter int DEBOUNCE_CYC = KEY_DEB_CYC_50M,
  parameter int LONG_CYC     = KEY_LONG_CYC_50M
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  key_if.slave kif
);

  logic [KEY_NUM-1:0] state_w;
  logic [KEY_NUM-1:0] press_w;
  logic [KEY_NUM-1:0] rel_w;
  logic [KEY_NUM-1:0] long_w;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
    ) u_ch (
      .clk_i     (sys_clk),
      .rst_ni    (sys_rst_n),
      .key_i     (kif.key_in[g]),
      .state_o   (state_w[g]),
      .press_o   (press_w[g]),
      .release_o (rel_w[g]),
      .long_o    (long_w[g])
    );
  end

  assign kif.key_state   = state_w;
  assign kif.key_press   = press_w;
  assign kif.key_release = rel_w;
  assign kif.key_long    = long_w;

endmodule

// File: tb/tb_key_input.sv
// key_input bench: directed scenarios + random bounce vs run-length model.
// Long-press expectations follow KEY_LONG_PRESS_EN.
module tb_key_input;
  import key_pkg::*;

  localparam int N   = 4;
  localparam int DEB = KEY_DEB_CYC_SIM;
  localparam int LNG = KEY_LONG_CYC_SIM;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  key_if #(.KEY_NUM(N)) kif ();

  key_input #(
    .KEY_NUM      (N),
    .DEBOUNCE_CYC (DEB),
    .LONG_CYC     (LNG)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .kif       (kif.slave)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model: sync pipe, debounced level, disagreement run, hold age
  logic [N-1:0] m_s1 = '1;
  logic [N-1:0] m_s2 = '1;
  logic [N-1:0] lvl = '0;
  logic [N-1:0] exp_p = '0;
  logic [N-1:0] exp_r = '0;
  logic [N-1:0] exp_l = '0;
  int run [N];
  int age [N];

  int pc [N];
  int rc [N];
  int lc [N];
  int pat [N];
  int lat [N];
  int ncyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic clr();
    ncyc = 0;
    for (int i = 0; i < N; i++) begin
      pc[i] = 0; rc[i] = 0; lc[i] = 0;
      pat[i] = -1; lat[i] = -1;
    end
  endtask

  task automatic model_step(input logic [N-1:0] k, input logic r);
    logic [N-1:0] s;
    logic was;
    exp_p = '0; exp_r = '0; exp_l = '0;
    if (!r) begin
      m_s1 = '1; m_s2 = '1; lvl = '0;
      for (int i = 0; i < N; i++) begin
        run[i] = 0; age[i] = 0;
      end
      return;
    end
    s = m_s2; m_s2 = m_s1; m_s1 = k;
    for (int i = 0; i < N; i++) begin
      was = lvl[i];
      // raw 0 = pressed, so equal bits mean the sample disagrees
      if (s[i] == lvl[i]) begin
        run[i]++;
        if (run[i] == DEB) begin
          lvl[i] = ~lvl[i];
          run[i] = 0;
          if (lvl[i]) exp_p[i] = 1'b1;
          else exp_r[i] = 1'b1;
        end
      end else begin
        run[i] = 0;
      end
      if (was && lvl[i]) begin
        if (age[i] < LNG) begin
          age[i]++;
          if (age[i] == LNG) exp_l[i] = LONG_EN;
        end
      end else begin
        age[i] = 0;
      end
    end
  endtask

  task automatic cyc(input logic [N-1:0] k, input logic r);
    @(negedge clk);
    kif.key_in = k;
    rst_n = r;
    @(posedge clk);
    model_step(k, r);
    #1;
    chk("state", kif.key_state, lvl);
    chk("press", kif.key_press, exp_p);
    chk("release", kif.key_release, exp_r);
    chk("long", kif.key_long, exp_l);
    chk("excl", kif.key_press & kif.key_release, '0);
    ncyc++;
    for (int i = 0; i < N; i++) begin
      if (kif.key_press[i]) begin
        pc[i]++;
        if (pat[i] < 0) pat[i] = ncyc;
      end
      if (kif.key_release[i]) rc[i]++;
      if (kif.key_long[i]) begin
        lc[i]++;
        if (lat[i] < 0) lat[i] = ncyc;
      end
    end
  endtask

  task automatic rst_now();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {kif.key_state, kif.key_press,
                      kif.key_release, kif.key_long}, '0);
  endtask

  logic [N-1:0] rk;
  int seg_len;
  int pflip;

  initial begin
    kif.key_in = '0;
    clr();

    // reset with all keys held, then fresh presses after release
    repeat (3) cyc(4'b0000, 1'b0);
    clr();
    repeat (14) cyc(4'b0000, 1'b1);
    for (int i = 0; i < N; i++) begin
      chk("rst_press_cnt", pc[i], 1);
      chk("rst_press_at", pat[i], 10);
    end

    clr();
    repeat (14) cyc(4'b1111, 1'b1);
    chk("rel_all_cnt", rc[0] + rc[1] + rc[2] + rc[3], 4);

    // clean simultaneous press ch0/ch1
    clr();
    repeat (14) cyc(4'b1100, 1'b1);
    chk("clean_at0", pat[0], 10);
    chk("clean_at1", pat[1], 10);
    chk("clean_cnt", pc[0] + pc[1], 2);
    repeat (14) cyc(4'b1111, 1'b1);

    // bounce on ch1: toggle every 3 cycles, then settle low
    clr();
    for (int i = 0; i < 30; i++)
      cyc({2'b11, ((i / 3) % 2 == 0) ? 1'b0 : 1'b1, 1'b1}, 1'b1);
    chk("bnc_quiet", pc[1], 0);
    repeat (14) cyc(4'b1101, 1'b1);
    chk("bnc_cnt", pc[1], 1);
    chk("bnc_at", pat[1], 40);

    // release glitch on ch2
    repeat (14) cyc(4'b1011, 1'b1);
    clr();
    repeat (5) cyc(4'b1111, 1'b1);
    repeat (12) cyc(4'b1011, 1'b1);
    chk("glitch_rel", rc[2], 0);
    chk("glitch_state", kif.key_state[2], 1);
    clr();
    repeat (12) cyc(4'b1111, 1'b1);
    chk("glitch_real_rel", rc[2], 1);

    // long press on ch3
    clr();
    repeat (80) cyc(4'b0111, 1'b1);
    chk("long_press_at", pat[3], 10);
    chk("long_cnt", lc[3], LONG_EN ? 1 : 0);
    chk("long_at", lat[3], LONG_EN ? 42 : -1);
    repeat (14) cyc(4'b1111, 1'b1);

    // reset during PRESS_CHK
    clr();
    repeat (4) cyc(4'b1100, 1'b1);
    rst_now();
    repeat (3) cyc(4'b1100, 1'b0);
    repeat (14) cyc(4'b1111, 1'b1);
    chk("rst_mid_press", pc[0] + pc[1], 0);

    // random bounce segments with occasional reset
    rk = '1;
    for (int s = 0; s < 40; s++) begin
      seg_len = $urandom_range(20, 120);
      case ($urandom_range(0, 2))
        0: pflip = 2;
        1: pflip = 10;
        default: pflip = 40;
      endcase
      for (int c = 0; c < seg_len; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 99) < pflip) rk[i] = ~rk[i];
        if ($urandom_range(0, 199) == 0) begin
          rst_now();
          cyc(rk, 1'b0);
        end else begin
          cyc(rk, 1'b1);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
